// File: rtl/fetch_prefetch_queue_if.sv
// Fetch front-end bus: instruction-memory request/response, branch redirect,
// and the valid/ready handshake toward the fetch/decode register.
interface fetch_prefetch_queue_if #(
    parameter int unsigned PC_W = 12
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_valid;
    logic [31:0]     imem_rdata;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
    logic            fd_ready;
    logic            if_valid;
    logic [31:0]     if_instr;
    logic [PC_W-1:0] if_pc;

    // Prefetch queue side
    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_pc,
        input  imem_ready, imem_valid, imem_rdata, redirect, redirect_pc, fd_ready
    );

    // Memory / pipeline / branch-unit side
    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_pc,
        output imem_ready, imem_valid, imem_rdata, redirect, redirect_pc, fd_ready
    );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, keeps at most one request
// outstanding to a variable-latency memory, buffers PC-tagged responses in a
// small FIFO, and flushes everything on a branch redirect.
module fetch_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned PC_W     = 12,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    fetch_prefetch_queue_if.master bus
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
    } entry_t;

    state_t          state, state_nxt;
    logic [PC_W-1:0] fetch_pc, fetch_pc_nxt;
    logic [PC_W-1:0] pend_pc, pend_pc_nxt;
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;
    entry_t          fifo [DEPTH];

    logic not_full, not_empty, issue, push, pop;

    // Handshake qualifiers; a redirect suppresses issue, push and pop
    assign not_full  = count < CNT_W'(DEPTH);
    assign not_empty = count != '0;
    assign issue     = bus.imem_req && bus.imem_ready;
    assign push      = (state == WAIT) && bus.imem_valid && !bus.redirect;
    assign pop       = not_empty && !bus.redirect && bus.fd_ready;

    // Combinational outputs toward memory and the fetch/decode register
    assign bus.imem_req  = (state == IDLE) && not_full && !bus.redirect;
    assign bus.imem_addr = fetch_pc;
    assign bus.if_valid  = not_empty && !bus.redirect;
    assign bus.if_instr  = not_empty ? fifo[rd_ptr].instr : 32'h0;
    assign bus.if_pc     = not_empty ? fifo[rd_ptr].pc : PC_W'(0);

    // Next-state: request tracking and fetch PC update
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        pend_pc_nxt  = pend_pc;
        case (state)
            IDLE: if (issue) state_nxt = WAIT;
            WAIT: begin
                if (bus.imem_valid)    state_nxt = IDLE;
                else if (bus.redirect) state_nxt = DROP;
            end
            // The outstanding response belongs to a squashed path; it retires here
            DROP: if (bus.imem_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (issue) begin
            pend_pc_nxt  = fetch_pc;
            fetch_pc_nxt = fetch_pc + PC_W'(4);
        end
        if (bus.redirect) begin
            fetch_pc_nxt = bus.redirect_pc & ~PC_W'(3);
        end
    end

    // State and PC registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= PC_W'(RESET_PC);
            pend_pc  <= '0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            pend_pc  <= pend_pc_nxt;
        end
    end

    // FIFO pointers and occupancy; redirect empties the queue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (bus.redirect) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    // FIFO storage; contents are only visible when count is non-zero
    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= '{pc: pend_pc, instr: bus.imem_rdata};
    end
endmodule
